// File: rtl/ps2_command_decoder.sv
// PS/2 scancode-to-command decoder: prefix tracking, file-id entry, run control,
// clamped viewport pan/zoom, manual cursor and typematic suppression for M/Space.
module ps2_command_decoder #(
    parameter int GRID_N       = 64,
    parameter int GRID_M       = 64,
    parameter int WIDTH        = 12,
    parameter int DIGITS       = 2,
    parameter int FILE_COUNT   = 100,
    parameter int MAX_ZOOM     = 5,
    parameter int MAX_SPEED    = 5,
    parameter int STEP_BASE    = 16,
    parameter int PULSE_CYCLES = 65536
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic [7:0]            scancode,
    input  logic                  scancode_valid,
    output logic                  start,
    output logic                  pause,
    output logic                  clear,
    output logic                  reload,
    output logic                  modify,
    output logic                  id_err,
    output logic                  running,
    output logic                  manual,
    output logic [15:0]           file_id,
    output logic [WIDTH-1:0]      shift_x,
    output logic [WIDTH-1:0]      shift_y,
    output logic [2:0]            scroll,
    output logic [3:0]            evo_left_shift,
    output logic [WIDTH-1:0]      cur_h,
    output logic [WIDTH-1:0]      cur_v,
    output logic [2*WIDTH-1:0]    cur_pos,
    output logic [4*DIGITS-1:0]   dpy_number
);

    localparam int EW  = 4 * DIGITS;
    localparam int CW  = $clog2(DIGITS + 1);
    localparam int PCW = $clog2(PULSE_CYCLES) + 1;
    localparam int SW  = WIDTH + 2;

    localparam logic [7:0] K_BRK = 8'hF0, K_EXT = 8'hE0, K_ESC = 8'h76, K_TAB = 8'h0D;
    localparam logic [7:0] K_LSH = 8'h12, K_ENT = 8'h5A, K_P = 8'h4D, K_R = 8'h2D;
    localparam logic [7:0] K_M = 8'h3A, K_SP = 8'h29, K_LT = 8'h41, K_GT = 8'h49;
    localparam logic [7:0] K_PLUS = 8'h55, K_MINUS = 8'h4E;
    localparam logic [7:0] K_W = 8'h1D, K_A = 8'h1C, K_S = 8'h1B, K_D = 8'h23;
    localparam logic [7:0] K_UP = 8'h75, K_LEFT = 8'h6B, K_DOWN = 8'h72, K_RIGHT = 8'h74;

    typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EBRK} state_t;

    state_t state, state_n;
    logic   act, rel, ext;

    logic [EW-1:0]  entry, entry_n, new_entry;
    logic [CW-1:0]  ecnt, ecnt_n;
    logic [PCW-1:0] pcnt, pcnt_n;
    logic           hold_m, hold_m_n, hold_sp, hold_sp_n;
    logic           start_n, pause_n, clear_n, reload_n, modify_n, id_err_n;
    logic           running_n, manual_n, view_rst, shift_wr;
    logic [2:0]     fire;
    logic [15:0]    file_id_n, value;
    logic [4:0]     dig;
    logic [WIDTH-1:0] sx_n, sy_n, ch_n, cv_n;
    logic [2:0]     scroll_n;
    logic [3:0]     speed_n;
    logic signed [SW-1:0] dx, dy, st;
    logic           go_l, go_r, go_u, go_d;
    int             step;

    function automatic logic [4:0] digit_of(input logic [7:0] c);
        case (c)
            8'h45: return 5'h10;
            8'h16: return 5'h11;
            8'h1E: return 5'h12;
            8'h26: return 5'h13;
            8'h25: return 5'h14;
            8'h2E: return 5'h15;
            8'h36: return 5'h16;
            8'h3D: return 5'h17;
            8'h3E: return 5'h18;
            8'h46: return 5'h19;
            default: return 5'h00;
        endcase
    endfunction

    function automatic logic [15:0] bcd_to_bin(input logic [EW-1:0] b);
        logic [15:0] acc;
        acc = '0;
        for (int i = DIGITS - 1; i >= 0; i--)
            acc = acc * 16'd10 + 16'(b[4*i +: 4]);
        return acc;
    endfunction

    // Double-dabble; ids never exceed DIGITS decimal digits so the top is truncated.
    function automatic logic [EW-1:0] bin_to_bcd(input logic [15:0] b);
        logic [EW+15:0] s;
        s = {{EW{1'b0}}, b};
        for (int i = 0; i < 16; i++) begin
            for (int d = 0; d < DIGITS; d++)
                if (s[16+4*d +: 4] >= 4'd5) s[16+4*d +: 4] = s[16+4*d +: 4] + 4'd3;
            s = s << 1;
        end
        return s[EW+15:16];
    endfunction

    // Keeps the visible window inside the grid: 0 <= v <= dim - (dim >> sc).
    function automatic logic [WIDTH-1:0] sat_shift(input logic signed [SW-1:0] v,
                                                   input int dim, input logic [2:0] sc);
        logic signed [SW-1:0] hi;
        hi = $signed(SW'(dim - (dim >> sc)));
        if (v[SW-1]) return '0;
        if (v > hi) return hi[WIDTH-1:0];
        return v[WIDTH-1:0];
    endfunction

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (scancode_valid) begin
            case (state)
                S_IDLE:  state_n = (scancode == K_BRK) ? S_BRK :
                                   (scancode == K_EXT) ? S_EXT : S_IDLE;
                S_EXT:   state_n = (scancode == K_BRK) ? S_EBRK : S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_comb begin
        act = 1'b0;
        rel = 1'b0;
        ext = 1'b0;
        if (scancode_valid) begin
            case (state)
                S_IDLE:  act = (scancode != K_BRK) && (scancode != K_EXT);
                S_EXT:   begin act = (scancode != K_BRK); ext = 1'b1; end
                S_BRK:   rel = 1'b1;
                default: begin rel = 1'b1; ext = 1'b1; end
            endcase
        end
    end

    always_comb begin
        start_n = start; pause_n = pause; clear_n = clear; pcnt_n = pcnt;
        reload_n = 1'b0; modify_n = 1'b0; id_err_n = 1'b0;
        running_n = running; manual_n = manual; file_id_n = file_id;
        sx_n = shift_x; sy_n = shift_y; scroll_n = scroll; speed_n = evo_left_shift;
        ch_n = cur_h; cv_n = cur_v; entry_n = entry; ecnt_n = ecnt;
        hold_m_n = hold_m; hold_sp_n = hold_sp;
        fire = 3'b000; view_rst = 1'b0; shift_wr = 1'b0; dx = '0; dy = '0;
        dig = digit_of(scancode);
        new_entry = (entry << 4) | EW'(dig[3:0]);
        value = bcd_to_bin(new_entry);
        step = STEP_BASE >> scroll;
        if (step < 1) step = 1;
        st = $signed(SW'(step));
        go_l = act && ((!ext && scancode == K_A) || (ext && scancode == K_LEFT));
        go_r = act && ((!ext && scancode == K_D) || (ext && scancode == K_RIGHT));
        go_u = act && ((!ext && scancode == K_W) || (ext && scancode == K_UP));
        go_d = act && ((!ext && scancode == K_S) || (ext && scancode == K_DOWN));

        if (start || pause || clear) begin
            if (pcnt == '0) begin
                start_n = 1'b0; pause_n = 1'b0; clear_n = 1'b0;
            end else begin
                pcnt_n = pcnt - 1'b1;
            end
        end

        if (rel && !ext) begin
            if (scancode == K_M)  hold_m_n  = 1'b0;
            if (scancode == K_SP) hold_sp_n = 1'b0;
        end

        if (act && !ext && dig[4]) begin
            if (ecnt == CW'(DIGITS - 1)) begin
                if (int'(value) < FILE_COUNT && !running) begin
                    file_id_n = value;
                    reload_n  = 1'b1;
                    view_rst  = 1'b1;
                end else begin
                    id_err_n = 1'b1;
                end
                entry_n = '0;
                ecnt_n  = '0;
            end else begin
                entry_n = new_entry;
                ecnt_n  = ecnt + 1'b1;
            end
        end else if (act && !ext) begin
            case (scancode)
                K_ESC: begin entry_n = '0; ecnt_n = '0; end
                K_TAB: if (!running) begin
                    file_id_n = (file_id == 16'(FILE_COUNT - 1)) ? 16'd0 : file_id + 16'd1;
                    reload_n  = 1'b1;
                end
                K_LSH: if (!running) begin
                    file_id_n = (file_id == 16'd0) ? 16'(FILE_COUNT - 1) : file_id - 16'd1;
                    reload_n  = 1'b1;
                end
                K_ENT: if (!running) begin
                    fire = 3'b001; running_n = 1'b1; manual_n = 1'b0;
                    entry_n = '0; ecnt_n = '0;
                end
                K_P: if (running) begin fire = 3'b010; running_n = 1'b0; end
                K_R: begin
                    fire = 3'b100; reload_n = 1'b1; running_n = 1'b0;
                    manual_n = 1'b0; view_rst = 1'b1;
                end
                K_M: begin
                    if (!running && !hold_m) manual_n = !manual;
                    hold_m_n = 1'b1;
                end
                K_SP: begin
                    if (manual && !hold_sp) modify_n = 1'b1;
                    hold_sp_n = 1'b1;
                end
                K_LT: if (evo_left_shift < 4'(MAX_SPEED)) speed_n = evo_left_shift + 4'd1;
                K_GT: if (evo_left_shift != 4'd0) speed_n = evo_left_shift - 4'd1;
                K_PLUS: if (scroll < 3'(MAX_ZOOM)) begin
                    scroll_n = scroll + 3'd1;
                    shift_wr = 1'b1;
                    dx = $signed(SW'(GRID_N >> (int'(scroll) + 2)));
                    dy = $signed(SW'(GRID_M >> (int'(scroll) + 2)));
                end
                K_MINUS: if (scroll != 3'd0) begin
                    scroll_n = scroll - 3'd1;
                    shift_wr = 1'b1;
                    dx = -$signed(SW'(GRID_N >> (int'(scroll) + 1)));
                    dy = -$signed(SW'(GRID_M >> (int'(scroll) + 1)));
                end
                default: ;
            endcase
        end

        if (go_l || go_r || go_u || go_d) begin
            if (manual) begin
                if (go_l && cur_h != '0) ch_n = cur_h - 1'b1;
                if (go_r && cur_h != WIDTH'(GRID_N - 1)) ch_n = cur_h + 1'b1;
                if (go_u && cur_v != '0) cv_n = cur_v - 1'b1;
                if (go_d && cur_v != WIDTH'(GRID_M - 1)) cv_n = cur_v + 1'b1;
            end else begin
                shift_wr = 1'b1;
                dx = go_l ? -st : (go_r ? st : '0);
                dy = go_u ? -st : (go_d ? st : '0);
            end
        end

        if (shift_wr) begin
            sx_n = sat_shift($signed({2'b00, shift_x}) + dx, GRID_N, scroll_n);
            sy_n = sat_shift($signed({2'b00, shift_y}) + dy, GRID_M, scroll_n);
        end

        // A newly fired control pulse cancels whichever one is still counting.
        if (fire != 3'b000) begin
            {clear_n, pause_n, start_n} = fire;
            pcnt_n = PCW'(PULSE_CYCLES - 1);
        end

        if (view_rst) begin
            sx_n = '0; sy_n = '0; scroll_n = '0; speed_n = '0;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            start <= 1'b0; pause <= 1'b0; clear <= 1'b0; pcnt <= '0;
            reload <= 1'b0; modify <= 1'b0; id_err <= 1'b0;
            running <= 1'b0; manual <= 1'b0; file_id <= '0;
            shift_x <= '0; shift_y <= '0; scroll <= '0; evo_left_shift <= '0;
            cur_h <= WIDTH'(GRID_N / 2);
            cur_v <= WIDTH'(GRID_M / 2);
            cur_pos <= (2*WIDTH)'((GRID_M / 2) * GRID_N + GRID_N / 2);
            entry <= '0; ecnt <= '0; hold_m <= 1'b0; hold_sp <= 1'b0;
        end else begin
            start <= start_n; pause <= pause_n; clear <= clear_n; pcnt <= pcnt_n;
            reload <= reload_n; modify <= modify_n; id_err <= id_err_n;
            running <= running_n; manual <= manual_n; file_id <= file_id_n;
            shift_x <= sx_n; shift_y <= sy_n; scroll <= scroll_n; evo_left_shift <= speed_n;
            cur_h <= ch_n;
            cur_v <= cv_n;
            cur_pos <= (2*WIDTH)'(cv_n) * (2*WIDTH)'(GRID_N) + (2*WIDTH)'(ch_n);
            entry <= entry_n; ecnt <= ecnt_n; hold_m <= hold_m_n; hold_sp <= hold_sp_n;
        end
    end

    always_comb dpy_number = (ecnt != '0) ? entry : bin_to_bcd(file_id);

endmodule

// File: tb/tb_ps2_command_decoder.sv
// Scoreboard bench for ps2_command_decoder: expectations are queued with a due
// cycle when a byte is sent and compared by a monitor on the falling edge.
module tb_ps2_command_decoder;
    localparam int W  = 12;
    localparam int D  = 2;
    localparam int PC = 20;
    localparam int FC = 20;

    logic clk_in = 1'b0, reset = 1'b0;
    logic [7:0] scancode = 8'h00;
    logic scancode_valid = 1'b0;
    logic start, pause, clear, reload, modify, id_err, running, manual;
    logic [15:0] file_id;
    logic [W-1:0] shift_x, shift_y, cur_h, cur_v;
    logic [2:0] scroll;
    logic [3:0] evo_left_shift;
    logic [2*W-1:0] cur_pos;
    logic [4*D-1:0] dpy_number;

    always #10 clk_in = ~clk_in;

    ps2_command_decoder #(.GRID_N(64), .GRID_M(64), .WIDTH(W), .DIGITS(D),
        .FILE_COUNT(FC), .MAX_ZOOM(5), .MAX_SPEED(5), .STEP_BASE(16),
        .PULSE_CYCLES(PC)) dut (
        .clk_in(clk_in), .reset(reset), .scancode(scancode), .scancode_valid(scancode_valid),
        .start(start), .pause(pause), .clear(clear), .reload(reload), .modify(modify),
        .id_err(id_err), .running(running), .manual(manual), .file_id(file_id),
        .shift_x(shift_x), .shift_y(shift_y), .scroll(scroll), .evo_left_shift(evo_left_shift),
        .cur_h(cur_h), .cur_v(cur_v), .cur_pos(cur_pos), .dpy_number(dpy_number));

    localparam int G_START = 0, G_PAUSE = 1, G_CLEAR = 2, G_RELOAD = 3, G_MODIFY = 4;
    localparam int G_IDERR = 5, G_RUN = 6, G_MAN = 7, G_FID = 8, G_SX = 9, G_SY = 10;
    localparam int G_SCR = 11, G_SPD = 12, G_CH = 13, G_CV = 14, G_POS = 15, G_DPY = 16;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] val;
        int          due;
    } exp_t;

    exp_t sb[$];
    int cyc = 0, last_due = 0, n_vec = 0, n_err = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic logic [31:0] observe(input int s);
        case (s)
            G_START:  return 32'(start);
            G_PAUSE:  return 32'(pause);
            G_CLEAR:  return 32'(clear);
            G_RELOAD: return 32'(reload);
            G_MODIFY: return 32'(modify);
            G_IDERR:  return 32'(id_err);
            G_RUN:    return 32'(running);
            G_MAN:    return 32'(manual);
            G_FID:    return 32'(file_id);
            G_SX:     return 32'(shift_x);
            G_SY:     return 32'(shift_y);
            G_SCR:    return 32'(scroll);
            G_SPD:    return 32'(evo_left_shift);
            G_CH:     return 32'(cur_h);
            G_CV:     return 32'(cur_v);
            G_POS:    return 32'(cur_pos);
            default:  return 32'(dpy_number);
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_in) begin : monitor
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].due == cyc) begin
                check_val(sb[i].tag, observe(sb[i].sig), sb[i].val);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic expv(input string tag, input int sig, input int val, input int off = 0);
        exp_t e;
        e.tag = tag; e.sig = sig; e.val = 32'(val); e.due = last_due + off;
        sb.push_back(e);
    endtask

    task automatic send(input logic [7:0] c);
        @(posedge clk_in); #1;
        scancode = c; scancode_valid = 1'b1;
        last_due = cyc + 1;
        @(posedge clk_in); #1;
        scancode_valid = 1'b0;
    endtask

    task automatic do_reset(input string pfx);
        @(posedge clk_in); #1;
        reset = 1'b1;
        last_due = cyc + 1;
        expv({pfx, "_start"}, G_START, 0);  expv({pfx, "_pause"}, G_PAUSE, 0);
        expv({pfx, "_clear"}, G_CLEAR, 0);  expv({pfx, "_reload"}, G_RELOAD, 0);
        expv({pfx, "_modify"}, G_MODIFY, 0); expv({pfx, "_iderr"}, G_IDERR, 0);
        expv({pfx, "_run"}, G_RUN, 0);      expv({pfx, "_man"}, G_MAN, 0);
        expv({pfx, "_fid"}, G_FID, 0);      expv({pfx, "_sx"}, G_SX, 0);
        expv({pfx, "_sy"}, G_SY, 0);        expv({pfx, "_scr"}, G_SCR, 0);
        expv({pfx, "_spd"}, G_SPD, 0);      expv({pfx, "_ch"}, G_CH, 32);
        expv({pfx, "_cv"}, G_CV, 32);       expv({pfx, "_pos"}, G_POS, 2080);
        expv({pfx, "_dpy"}, G_DPY, 0);
        @(posedge clk_in); #1;
        reset = 1'b0;
    endtask

    initial begin
        do_reset("rst");

        // file-id entry, commit and escape
        send(8'h16); expv("entry1_dpy", G_DPY, 'h01); expv("entry1_fid", G_FID, 0);
        send(8'h1E); expv("commit_fid", G_FID, 12); expv("commit_reload", G_RELOAD, 1);
        expv("commit_dpy", G_DPY, 'h12); expv("reload_1cyc", G_RELOAD, 0, 1);
        send(8'h16); send(8'h76); expv("esc_fid", G_FID, 12); expv("esc_dpy", G_DPY, 'h12);
        send(8'h1E); expv("err_dpy", G_DPY, 'h02);
        send(8'h45); expv("range_err", G_IDERR, 1); expv("range_fid", G_FID, 12);
        expv("err_1cyc", G_IDERR, 0, 1);
        send(8'h16); send(8'h46); expv("commit19", G_FID, 19);
        send(8'h0D); expv("tab_wrap", G_FID, 0); expv("tab_reload", G_RELOAD, 1);
        send(8'h12); expv("lsh_wrap", G_FID, 19);

        // run control and pulse length
        send(8'h5A); expv("start_on", G_START, 1); expv("run_set", G_RUN, 1);
        expv("start_last", G_START, 1, PC - 1); expv("start_off", G_START, 0, PC);
        expv("enter_dpy", G_DPY, 'h19);
        send(8'h16); send(8'h16); expv("run_iderr", G_IDERR, 1); expv("run_fid", G_FID, 19);
        send(8'h0D); expv("run_tab", G_FID, 19); expv("run_tab_rl", G_RELOAD, 0);
        repeat (25) @(posedge clk_in);
        send(8'h4D); expv("pause_on", G_PAUSE, 1); expv("pause_run", G_RUN, 0);
        expv("pause_off", G_PAUSE, 0, PC);
        repeat (25) @(posedge clk_in);
        send(8'h5A); expv("start2_on", G_START, 1);
        send(8'h2D); expv("r_cancel", G_START, 0); expv("r_clear", G_CLEAR, 1);
        expv("r_reload", G_RELOAD, 1); expv("r_run", G_RUN, 0); expv("r_clear_off", G_CLEAR, 0, PC);

        // zoom, pan clamp, speed
        send(8'h55); expv("zin1_scr", G_SCR, 1); expv("zin1_sx", G_SX, 16); expv("zin1_sy", G_SY, 16);
        send(8'h55); expv("zin2_scr", G_SCR, 2); expv("zin2_sx", G_SX, 24);
        send(8'h23); expv("pan1_sx", G_SX, 28);
        repeat (19) send(8'h23);
        expv("pan_sat_sx", G_SX, 48); expv("pan_sy", G_SY, 24);
        send(8'h4E); expv("zout1_scr", G_SCR, 1); expv("zout1_sx", G_SX, 32); expv("zout1_sy", G_SY, 16);
        send(8'h4E); expv("zout2_scr", G_SCR, 0); expv("zout2_sx", G_SX, 0); expv("zout2_sy", G_SY, 0);
        repeat (7) send(8'h41);
        expv("spd_sat", G_SPD, 5);
        send(8'h49); expv("spd_dec", G_SPD, 4);
        repeat (6) send(8'h55);
        expv("zmax_scr", G_SCR, 5); expv("zmax_sx", G_SX, 31); expv("zmax_sy", G_SY, 31);
        send(8'h1C); expv("step_min", G_SX, 30);
        send(8'h2D); expv("r_scr", G_SCR, 0); expv("r_sx", G_SX, 0); expv("r_spd", G_SPD, 0);

        // manual mode, typematic suppression, cursor
        send(8'h3A); expv("m_on", G_MAN, 1);
        send(8'h3A); expv("m_repeat", G_MAN, 1);
        send(8'hF0); send(8'h3A); expv("m_break", G_MAN, 1);
        send(8'h3A); expv("m_off", G_MAN, 0);
        send(8'hF0); send(8'h3A); send(8'h3A); expv("m_on2", G_MAN, 1);
        send(8'h29); expv("sp_mod", G_MODIFY, 1); expv("sp_1cyc", G_MODIFY, 0, 1);
        send(8'h29); expv("sp_repeat", G_MODIFY, 0);
        send(8'hF0); send(8'h29); send(8'h29); expv("sp_mod2", G_MODIFY, 1);
        repeat (40) send(8'h1C);
        expv("cur_h_min", G_CH, 0); expv("cur_pos0", G_POS, 2048); expv("man_sx", G_SX, 0);
        send(8'h1D); expv("cur_up", G_CV, 31); expv("pos_up", G_POS, 1984);
        send(8'hE0); send(8'h74); expv("arrow_r", G_CH, 1); expv("pos_r", G_POS, 1985);
        send(8'hE0); send(8'hF0); send(8'h75); expv("ebrk_cv", G_CV, 31); expv("ebrk_pos", G_POS, 1985);
        send(8'hE0); send(8'h75); expv("arrow_u", G_CV, 30); expv("pos_u", G_POS, 1921);
        repeat (70) send(8'h23);
        expv("cur_h_max", G_CH, 63); expv("pos_max", G_POS, 1983);

        // reset during a start pulse and a partial entry
        send(8'h5A); expv("st3_on", G_START, 1); expv("st3_man", G_MAN, 0);
        send(8'h16); expv("st3_dpy", G_DPY, 'h01);
        do_reset("mid");

        for (int t = 0; t < 200 && sb.size() > 0; t++) @(posedge clk_in);
        @(negedge clk_in);
        while (sb.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: not compared, expected %0h", sb[0].tag, sb[0].val);
            void'(sb.pop_front());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
